// File: rtl/rv_imem_pkg.sv
// Shared types for the halfword-addressed instruction memory responder.
package rv_imem_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_LO
  } imem_state_t;

  // A halfword address is word-aligned when its halfword-select bit is clear.
  function automatic logic hw_is_aligned(input logic hw_sel);
    return ~hw_sel;
  endfunction

endpackage

// File: rtl/rv_fetch_imem_hold.sv
// Upper-half staging register for misaligned fetches, tagged with the word it holds.
// Hit reuse is only reported when FLEXRV_IMEM_HOLD_REUSE_EN is defined.
module rv_fetch_imem_hold
  import rv_imem_pkg::*;
#(
  parameter int WORD_W = 14
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rd_en,
  input  logic [WORD_W-1:0] i_rd_idx,
  input  logic [15:0]       i_mem_rdata_hi,
  input  logic [WORD_W-1:0] i_lookup_idx,
  output logic              o_hit,
  output logic [15:0]       o_hold_hi
);

`ifdef FLEXRV_IMEM_HOLD_REUSE_EN
  localparam bit REUSE_EN = 1'b1;
`else
  localparam bit REUSE_EN = 1'b0;
`endif

  logic              pend_q, pend_d;
  logic [WORD_W-1:0] pend_idx_q, pend_idx_d;
  logic              tag_vld_q, tag_vld_d;
  logic [WORD_W-1:0] tag_idx_q, tag_idx_d;
  logic [15:0]       hold_hi_q, hold_hi_d;

  always_comb begin
    pend_d     = i_rd_en;
    pend_idx_d = i_rd_idx;
    tag_vld_d  = tag_vld_q | pend_q;
    tag_idx_d  = pend_q ? pend_idx_q : tag_idx_q;
    hold_hi_d  = pend_q ? i_mem_rdata_hi : hold_hi_q;
  end

  // The lookup compares against the tag the register will carry next cycle,
  // so a read still in flight counts; that is when its data is consumed.
  assign o_hit     = REUSE_EN && tag_vld_d && (tag_idx_d == i_lookup_idx);
  assign o_hold_hi = hold_hi_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pend_q    <= 1'b0;
      tag_vld_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      tag_vld_q <= tag_vld_d;
    end
  end

  always_ff @(posedge i_clk) begin
    pend_idx_q <= pend_idx_d;
    tag_idx_q  <= tag_idx_d;
    hold_hi_q  <= hold_hi_d;
  end

endmodule

// File: rtl/rv_fetch_imem.sv
// Fetch-port responder returning 32-bit instructions at halfword addresses from word memory.
// Optional single-read misaligned reuse: define FLEXRV_IMEM_HOLD_REUSE_EN.
module rv_fetch_imem
  import rv_imem_pkg::*;
#(
  parameter int IADDR_SPACE_BITS = 16,
  parameter int WAIT_STATES      = 0
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_cyc,
  input  logic [IADDR_SPACE_BITS-1:1]   i_addr,
  output logic                          o_ack,
  output logic [31:0]                   o_instruction,
  output logic                          o_mem_re,
  output logic [IADDR_SPACE_BITS-1:2]   o_mem_addr,
  input  logic [31:0]                   i_mem_rdata
);

  localparam int        WORD_W   = IADDR_SPACE_BITS - 2;
  localparam wait_cnt_t WAIT_LIM = wait_cnt_t'(WAIT_STATES);

  imem_state_t       state_q, state_d;
  wait_cnt_t         wait_cnt_q, wait_cnt_d;
  logic              aligned_q, aligned_d;
  logic [WORD_W-1:0] w, w_next;
  logic              aligned;
  logic              hit;
  logic              serve;
  logic              ack_c, re_c;
  logic [WORD_W-1:0] addr_c;
  logic [15:0]       hold_hi;

  assign w       = i_addr[IADDR_SPACE_BITS-1:2];
  assign w_next  = w + WORD_W'(1);
  assign aligned = hw_is_aligned(i_addr[1]);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    aligned_d  = aligned;
    serve      = 1'b0;
    ack_c      = 1'b0;
    re_c       = 1'b0;
    addr_c     = w;

    case (state_q)
      S_IDLE: begin
        if (i_cyc) begin
          if (WAIT_STATES != 0) begin
            state_d    = S_WAIT;
            wait_cnt_d = wait_cnt_t'(1);
          end else begin
            serve = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!i_cyc) begin
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LIM) begin
          serve      = 1'b1;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + wait_cnt_t'(1);
        end
      end
      S_LO: begin
        state_d = S_IDLE;
        if (i_cyc) begin
          re_c   = 1'b1;
          ack_c  = 1'b1;
          addr_c = w_next;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A miss reads the low word now and the high word from S_LO next cycle.
    if (serve) begin
      re_c = 1'b1;
      if (aligned) begin
        ack_c   = 1'b1;
        state_d = S_IDLE;
      end else if (hit) begin
        ack_c   = 1'b1;
        addr_c  = w_next;
        state_d = S_IDLE;
      end else begin
        state_d = S_LO;
      end
    end
  end

  assign o_ack      = ack_c & ~i_reset;
  assign o_mem_re   = re_c & ~i_reset;
  assign o_mem_addr = addr_c;

  rv_fetch_imem_hold #(
    .WORD_W(WORD_W)
  ) u_hold (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_rd_en        (o_mem_re),
    .i_rd_idx       (o_mem_addr),
    .i_mem_rdata_hi (i_mem_rdata[31:16]),
    .i_lookup_idx   (w),
    .o_hit          (hit),
    .o_hold_hi      (hold_hi)
  );

  assign o_instruction = aligned_q ? i_mem_rdata : {i_mem_rdata[15:0], hold_hi};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    aligned_q <= aligned_d;
  end

`ifndef SYNTHESIS
  a_addr_stable: assert property (@(posedge i_clk) disable iff (i_reset)
    (i_cyc && !o_ack) |=> (!i_cyc || $stable(i_addr)))
    else $error("i_addr changed while request pending");
`endif

endmodule

// File: tb/tb_rv_fetch_imem.sv
// Directed bench for rv_fetch_imem: zero-wait instance plus a WAIT_STATES=2 instance.
module tb_rv_fetch_imem;

  logic        clk;
  logic        rst;
  logic        cyc, cyc2;
  logic [15:1] addr, addr2;
  logic        ack, ack2;
  logic [31:0] instr, instr2;
  logic        re, re2;
  logic [15:2] maddr, maddr2;
  logic [31:0] rdata, rdata2;

  logic [31:0] mem [0:16383];

  int checks = 0;
  int errors = 0;

  rv_fetch_imem #(.IADDR_SPACE_BITS(16), .WAIT_STATES(0)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_cyc         (cyc),
    .i_addr        (addr),
    .o_ack         (ack),
    .o_instruction (instr),
    .o_mem_re      (re),
    .o_mem_addr    (maddr),
    .i_mem_rdata   (rdata)
  );

  rv_fetch_imem #(.IADDR_SPACE_BITS(16), .WAIT_STATES(2)) dut_w (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_cyc         (cyc2),
    .i_addr        (addr2),
    .o_ack         (ack2),
    .o_instruction (instr2),
    .o_mem_re      (re2),
    .o_mem_addr    (maddr2),
    .i_mem_rdata   (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (re)  rdata  <= mem[maddr];
    if (re2) rdata2 <= mem[maddr2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[0]     = 32'h1111_2222;
    mem[1]     = 32'h3333_4444;
    mem[2]     = 32'h5555_6666;
    mem[16383] = 32'hABCD_0123;
    rdata  = 32'h0;
    rdata2 = 32'h0;
    rst  = 1'b1;
    cyc  = 1'b1;
    addr = 15'h0;
    cyc2 = 1'b0;
    addr2 = 15'h0;

    // Reset: outputs gated even with a request present
    nxt(); settle();
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_re", {31'h0, re}, 32'h0);
    nxt(); rst = 1'b0;

    // 1. aligned stream 0x0, 0x4, 0x8
    settle();
    chk("t1_ack0", {31'h0, ack}, 32'h1);
    chk("t1_re0", {31'h0, re}, 32'h1);
    chk("t1_addr0", {18'h0, maddr}, 32'h0);
    nxt(); addr = 15'h2; settle();
    chk("t1_ack1", {31'h0, ack}, 32'h1);
    chk("t1_addr1", {18'h0, maddr}, 32'h1);
    chk("t1_data0", instr, 32'h1111_2222);
    nxt(); addr = 15'h4; settle();
    chk("t1_ack2", {31'h0, ack}, 32'h1);
    chk("t1_addr2", {18'h0, maddr}, 32'h2);
    chk("t1_data1", instr, 32'h3333_4444);
    nxt(); cyc = 1'b0; settle();
    chk("t1_ack3", {31'h0, ack}, 32'h0);
    chk("t1_data2", instr, 32'h5555_6666);

    // 2. cold misaligned 0x2
    nxt(); cyc = 1'b1; addr = 15'h1; settle();
    chk("t2_ack0", {31'h0, ack}, 32'h0);
    chk("t2_re0", {31'h0, re}, 32'h1);
    chk("t2_addr0", {18'h0, maddr}, 32'h0);
    nxt(); settle();
    chk("t2_ack1", {31'h0, ack}, 32'h1);
    chk("t2_re1", {31'h0, re}, 32'h1);
    chk("t2_addr1", {18'h0, maddr}, 32'h1);
    nxt(); cyc = 1'b0; settle();
    chk("t2_ack2", {31'h0, ack}, 32'h0);
    chk("t2_data", instr, 32'h4444_1111);

    // 3. sequential misaligned 0x2 then 0x6
    nxt(); cyc = 1'b1; addr = 15'h1; settle();
    chk("t3_ack0", {31'h0, ack}, 32'h0);
    nxt(); settle();
    chk("t3_ack1", {31'h0, ack}, 32'h1);
    nxt(); addr = 15'h3; settle();
    chk("t3_data0", instr, 32'h4444_1111);
`ifdef FLEXRV_IMEM_HOLD_REUSE_EN
    chk("t3_hit_ack", {31'h0, ack}, 32'h1);
    chk("t3_hit_addr", {18'h0, maddr}, 32'h2);
    nxt(); cyc = 1'b0; settle();
    chk("t3_data1", instr, 32'h6666_3333);
`else
    chk("t3_miss_ack", {31'h0, ack}, 32'h0);
    chk("t3_miss_addr", {18'h0, maddr}, 32'h1);
    nxt(); settle();
    chk("t3_lo_ack", {31'h0, ack}, 32'h1);
    chk("t3_lo_addr", {18'h0, maddr}, 32'h2);
    nxt(); cyc = 1'b0; settle();
    chk("t3_data1", instr, 32'h6666_3333);
`endif

    // 4. abort in S_LO, then aligned 0x4
    nxt(); cyc = 1'b1; addr = 15'h1; settle();
    chk("t4_ack0", {31'h0, ack}, 32'h0);
    chk("t4_addr0", {18'h0, maddr}, 32'h0);
    nxt(); cyc = 1'b0; settle();
    chk("t4_abort_ack", {31'h0, ack}, 32'h0);
    chk("t4_abort_re", {31'h0, re}, 32'h0);
    nxt(); cyc = 1'b1; addr = 15'h2; settle();
    chk("t4_ack2", {31'h0, ack}, 32'h1);
    chk("t4_addr2", {18'h0, maddr}, 32'h1);
    nxt(); cyc = 1'b0; settle();
    chk("t4_data", instr, 32'h3333_4444);

    // 6. top word wrap 0xFFFE
    nxt(); cyc = 1'b1; addr = 15'h7FFF; settle();
    chk("t6_ack0", {31'h0, ack}, 32'h0);
    chk("t6_addr0", {18'h0, maddr}, 32'h3FFF);
    nxt(); settle();
    chk("t6_ack1", {31'h0, ack}, 32'h1);
    chk("t6_addr1", {18'h0, maddr}, 32'h0);
    nxt(); cyc = 1'b0; settle();
    chk("t6_data", instr, 32'h2222_ABCD);

    // 6b. reset while in S_LO, then 0x6 needs two reads
    nxt(); cyc = 1'b1; addr = 15'h3; settle();
    chk("t6r_ack0", {31'h0, ack}, 32'h0);
    chk("t6r_addr0", {18'h0, maddr}, 32'h1);
    nxt(); rst = 1'b1; settle();
    chk("t6r_rst_ack", {31'h0, ack}, 32'h0);
    chk("t6r_rst_re", {31'h0, re}, 32'h0);
    nxt(); rst = 1'b0; settle();
    chk("t6r_ack1", {31'h0, ack}, 32'h0);
    chk("t6r_re1", {31'h0, re}, 32'h1);
    chk("t6r_addr1", {18'h0, maddr}, 32'h1);
    nxt(); settle();
    chk("t6r_ack2", {31'h0, ack}, 32'h1);
    chk("t6r_addr2", {18'h0, maddr}, 32'h2);
    nxt(); cyc = 1'b0; settle();
    chk("t6r_data", instr, 32'h6666_3333);

    // 5. WAIT_STATES=2 instance
    nxt(); cyc2 = 1'b1; addr2 = 15'h0; settle();
    chk("t5_ack0", {31'h0, ack2}, 32'h0);
    chk("t5_re0", {31'h0, re2}, 32'h0);
    nxt(); settle();
    chk("t5_ack1", {31'h0, ack2}, 32'h0);
    chk("t5_re1", {31'h0, re2}, 32'h0);
    nxt(); settle();
    chk("t5_ack2", {31'h0, ack2}, 32'h1);
    chk("t5_re2", {31'h0, re2}, 32'h1);
    chk("t5_addr2", {18'h0, maddr2}, 32'h0);
    nxt(); cyc2 = 1'b0; settle();
    chk("t5_data", instr2, 32'h1111_2222);
    nxt(); cyc2 = 1'b1; addr2 = 15'h2; settle();
    chk("t5d_ack0", {31'h0, ack2}, 32'h0);
    nxt(); cyc2 = 1'b0; settle();
    chk("t5d_drop_ack", {31'h0, ack2}, 32'h0);
    chk("t5d_drop_re", {31'h0, re2}, 32'h0);
    nxt(); cyc2 = 1'b1; settle();
    chk("t5f_ack0", {31'h0, ack2}, 32'h0);
    nxt(); settle();
    chk("t5f_ack1", {31'h0, ack2}, 32'h0);
    chk("t5f_re1", {31'h0, re2}, 32'h0);
    nxt(); settle();
    chk("t5f_ack2", {31'h0, ack2}, 32'h1);
    chk("t5f_addr2", {18'h0, maddr2}, 32'h1);
    nxt(); cyc2 = 1'b0; settle();
    chk("t5f_data", instr2, 32'h3333_4444);

    nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
